// File: rtl/param_sync_fifo_if.sv
// Producer/consumer bundle for param_sync_fifo. The master side drives requests.
// The slave side (the FIFO) drives data, count and status flags.
interface param_sync_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) ();
  logic                     wr_en;
  logic [WIDTH-1:0]         wr_data;
  logic                     rd_en;
  logic [WIDTH-1:0]         rd_data;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     underflow;
  logic                     err_clr;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with registered status flags, fill count,
// sticky error flags and an optional first-word-fall-through read port.
module param_sync_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter bit          FWFT     = 1'b0
) (
  input logic              clk,
  input logic              reset,
  param_sync_fifo_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] AfLvl = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AeLvl = CW'(AE_LEVEL);
  localparam logic [CW-1:0] FullLvl = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_af;
  logic             r_ae;
  logic             r_ovf;
  logic             r_unf;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [CW-1:0]    w_count_nxt;

  assign w_wr_acc = bus.wr_en && !r_full;
  assign w_rd_acc = bus.rd_en && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_wr_acc && w_rd_acc) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Storage carries no reset; validity is tracked entirely by pointers and count.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FullLvl);
      r_empty <= (w_count_nxt == '0);
      r_af    <= (w_count_nxt >= AfLvl);
      r_ae    <= (w_count_nxt <= AeLvl);
      // A new error in the same cycle as err_clr keeps the flag set.
      r_ovf   <= (r_ovf && !bus.err_clr) || (bus.wr_en && r_full);
      r_unf   <= (r_unf && !bus.err_clr) || (bus.rd_en && r_empty);
    end
  end

  if (FWFT) begin : g_fwft
    assign bus.rd_data = r_mem[r_rptr];
  end else begin : g_std
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_rd_data <= '0;
      end else if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rptr];
      end
    end

    assign bus.rd_data = r_rd_data;
  end

  assign bus.count        = r_count;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_af;
  assign bus.almost_empty = r_ae;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_unf;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a standard-read and an FWFT instance share one stimulus
// stream and are compared against a queue model, a vector table and corner-case sequences.
module tb_param_sync_fifo;
  localparam int DEPTH = 16;
  localparam int AFL   = 14;
  localparam int AEL   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  param_sync_fifo_if #(.WIDTH(8), .DEPTH(DEPTH)) bus0 ();
  param_sync_fifo_if #(.WIDTH(8), .DEPTH(DEPTH)) bus1 ();

  assign bus0.wr_en = wr_en;  assign bus1.wr_en = wr_en;
  assign bus0.wr_data = wr_data;  assign bus1.wr_data = wr_data;
  assign bus0.rd_en = rd_en;  assign bus1.rd_en = rd_en;
  assign bus0.err_clr = err_clr;  assign bus1.err_clr = err_clr;

  param_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  param_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  // Behavioural model: contents as a queue, flags computed from its size.
  logic [7:0] q[$];
  logic [7:0] m_rd  = '0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       rd;
    logic       clr;
    int         cnt;
    logic       full;
    logic       af;
    logic       ovf;
    logic       chk_rd;
    logic [7:0] rd_exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Applies one cycle of stimulus; inputs change 1 time unit after a rising edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    int sz;
    wr_en = w; wr_data = d; rd_en = r; err_clr = c;
    sz = q.size();
    m_ovf = (m_ovf && !c) || (w && sz == DEPTH);
    m_unf = (m_unf && !c) || (r && sz == 0);
    if (r && sz > 0) m_rd = q.pop_front();
    if (w && sz < DEPTH) q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = q.size();
    chk({tag, "_count"}, 32'(bus0.count), 32'(sz));
    chk({tag, "_full"}, 32'(bus0.full), 32'(sz == DEPTH));
    chk({tag, "_empty"}, 32'(bus0.empty), 32'(sz == 0));
    chk({tag, "_afull"}, 32'(bus0.almost_full), 32'(sz >= AFL));
    chk({tag, "_aempty"}, 32'(bus0.almost_empty), 32'(sz <= AEL));
    chk({tag, "_ovf"}, 32'(bus0.overflow), 32'(m_ovf));
    chk({tag, "_unf"}, 32'(bus0.underflow), 32'(m_unf));
    chk({tag, "_rd_std"}, 32'(bus0.rd_data), 32'(m_rd));
    chk({tag, "_count_fwft"}, 32'(bus1.count), 32'(sz));
    chk({tag, "_empty_fwft"}, 32'(bus1.empty), 32'(sz == 0));
    chk({tag, "_flags_fwft"}, 32'({bus1.overflow, bus1.underflow}), 32'({m_ovf, m_unf}));
    if (sz > 0) chk({tag, "_rd_fwft"}, 32'(bus1.rd_data), 32'(q[0]));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_count"}, 32'(bus0.count), 32'd0);
    chk({tag, "_empty"}, 32'(bus0.empty), 32'd1);
    chk({tag, "_aempty"}, 32'(bus0.almost_empty), 32'd1);
    chk({tag, "_full"}, 32'(bus0.full), 32'd0);
    chk({tag, "_afull"}, 32'(bus0.almost_full), 32'd0);
    chk({tag, "_errs"}, 32'({bus0.overflow, bus0.underflow}), 32'd0);
    chk({tag, "_rd"}, 32'(bus0.rd_data), 32'd0);
    chk({tag, "_fwft"}, 32'({bus1.count, bus1.empty}), 32'({5'd0, 1'b1}));
  endtask

  initial begin
    vec_t v;
    int wb;
    int rb;

    // Fill, overflow attempt, drain in order, then clear the sticky flag.
    for (int i = 0; i < DEPTH; i++) begin
      v = '{wr: 1'b1, d: 8'(i), rd: 1'b0, clr: 1'b0, cnt: i + 1, full: (i == DEPTH - 1),
            af: (i + 1 >= AFL), ovf: 1'b0, chk_rd: 1'b0, rd_exp: 8'h00};
      tbl.push_back(v);
    end
    v = '{wr: 1'b1, d: 8'hAA, rd: 1'b0, clr: 1'b0, cnt: DEPTH, full: 1'b1, af: 1'b1,
          ovf: 1'b1, chk_rd: 1'b0, rd_exp: 8'h00};
    tbl.push_back(v);
    for (int i = 0; i < DEPTH; i++) begin
      v = '{wr: 1'b0, d: 8'h00, rd: 1'b1, clr: 1'b0, cnt: DEPTH - 1 - i, full: 1'b0,
            af: (DEPTH - 1 - i >= AFL), ovf: 1'b1, chk_rd: 1'b1, rd_exp: 8'(i)};
      tbl.push_back(v);
    end
    v = '{wr: 1'b0, d: 8'h00, rd: 1'b0, clr: 1'b1, cnt: 0, full: 1'b0, af: 1'b0, ovf: 1'b0,
          chk_rd: 1'b1, rd_exp: 8'h0F};
    tbl.push_back(v);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst_held");
    reset = 1'b0;
    #1;
    check_reset_state("rst_idle");

    foreach (tbl[i]) begin
      step(tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].clr);
      chk($sformatf("vec%0d_count", i), 32'(bus0.count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_full", i), 32'(bus0.full), 32'(tbl[i].full));
      chk($sformatf("vec%0d_afull", i), 32'(bus0.almost_full), 32'(tbl[i].af));
      chk($sformatf("vec%0d_ovf", i), 32'(bus0.overflow), 32'(tbl[i].ovf));
      if (tbl[i].chk_rd) chk($sformatf("vec%0d_rd", i), 32'(bus0.rd_data), 32'(tbl[i].rd_exp));
    end
    check_model("after_tbl");

    // Pointer wrap: three 10-in/10-out bursts, then steady streaming at count 5.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) begin
        step(1'b1, 8'($urandom), 1'b0, 1'b0);
        check_model("wrap_w");
      end
      for (int i = 0; i < 10; i++) begin
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_model("wrap_r");
      end
    end
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
      chk("stream_count5", 32'(bus0.count), 32'd5);
      check_model("stream");
    end
    while (q.size() > 0) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_model("drain");
    end

    // Underflow is sticky, cleared by err_clr, and a same-cycle new error wins.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_set", 32'(bus0.underflow), 32'd1);
    check_model("unf");
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("unf_clr", 32'(bus0.underflow), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("unf_set_wins", 32'(bus0.underflow), 32'd1);
    check_model("unf2");

    // FWFT: the written word appears with empty falling, before any read.
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("fwft_empty_low", 32'(bus1.empty), 32'd0);
    chk("fwft_data", 32'(bus1.rd_data), 32'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_pop_empty", 32'(bus1.empty), 32'd1);
    chk("std_read_5a", 32'(bus0.rd_data), 32'h5A);
    check_model("fwft");

    // Asynchronous reset while holding 7 entries and a pending underflow flag.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    chk("pre_rst_count7", 32'(bus0.count), 32'd7);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_state("rst_mid");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 8'h33, 1'b0, 1'b0);
    chk("post_rst_fwft33", 32'(bus1.rd_data), 32'h33);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_rd33", 32'(bus0.rd_data), 32'h33);
    check_model("post_rst");

    // Random traffic with alternating fill/drain bias.
    for (int ph = 0; ph < 8; ph++) begin
      wb = (ph % 2 == 0) ? 80 : 25;
      rb = (ph % 2 == 0) ? 25 : 80;
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 99) < wb, 8'($urandom), $urandom_range(0, 99) < rb,
             $urandom_range(0, 31) == 0);
        check_model("rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
